// File: rtl/f_fetch_queue.sv
// Instruction fetch queue: keeps at most one imem read outstanding and buffers the
// returned words in a DEPTH-entry FIFO for decode; flush drops queued and in-flight fetches.
module f_fetch_queue #(
    parameter int          DEPTH      = 4,
    parameter logic [31:0] RESET_ADDR = 32'h0000_3000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pc,
    output logic        pc_we,
    input  logic        flush,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        d_valid,
    input  logic        d_ready,
    output logic [31:0] d_instr,
    output logic [31:0] d_pc
);
    localparam int          PW         = $clog2(DEPTH);
    localparam logic [PW:0] FULL_COUNT = (PW+1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, WAIT, DROP} state_t;

    state_t        state_reg;
    logic          imem_req_reg;
    logic [31:0]   imem_addr_reg;
    logic [PW:0]   count_reg;
    logic [PW-1:0] rd_ptr_reg;
    logic [PW-1:0] wr_ptr_reg;

    logic [31:0]   entry_instr [DEPTH];
    logic [31:0]   entry_addr  [DEPTH];

    logic push;
    logic pop;
    logic issue;

    assign push  = (state_reg == WAIT) && imem_ack && !flush;
    assign pop   = (count_reg != '0) && d_ready && !flush;
    // Only issue while there is still a free slot, so an in-flight result always fits.
    assign issue = (state_reg == IDLE) && !flush && (count_reg < FULL_COUNT);

    // The PC advances on an accepted fetch and loads the redirect target on flush.
    assign pc_we = reset && (push || flush);

    assign imem_req  = imem_req_reg;
    assign imem_addr = imem_addr_reg;
    assign d_valid   = (count_reg != '0);
    assign d_instr   = entry_instr[rd_ptr_reg];
    assign d_pc      = entry_addr[rd_ptr_reg];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg     <= IDLE;
            imem_req_reg  <= 1'b0;
            imem_addr_reg <= RESET_ADDR;
            count_reg     <= '0;
            rd_ptr_reg    <= '0;
            wr_ptr_reg    <= '0;
        end else begin
            if (flush) begin
                count_reg  <= '0;
                rd_ptr_reg <= '0;
                wr_ptr_reg <= '0;
            end else begin
                if (push) begin
                    wr_ptr_reg <= wr_ptr_reg + PW'(1);
                end
                if (pop) begin
                    rd_ptr_reg <= rd_ptr_reg + PW'(1);
                end
                case ({push, pop})
                    2'b10:   count_reg <= count_reg + (PW+1)'(1);
                    2'b01:   count_reg <= count_reg - (PW+1)'(1);
                    default: count_reg <= count_reg;
                endcase
            end

            case (state_reg)
                IDLE: begin
                    if (issue) begin
                        state_reg     <= WAIT;
                        imem_req_reg  <= 1'b1;
                        imem_addr_reg <= pc;
                    end
                end
                WAIT: begin
                    if (imem_ack) begin
                        state_reg    <= IDLE;
                        imem_req_reg <= 1'b0;
                    end else if (flush) begin
                        state_reg <= DROP;
                    end
                end
                DROP: begin
                    if (imem_ack) begin
                        state_reg    <= IDLE;
                        imem_req_reg <= 1'b0;
                    end
                end
                default: begin
                    state_reg    <= IDLE;
                    imem_req_reg <= 1'b0;
                end
            endcase
        end
    end

    // Entries reset to RESET_ADDR so d_pc shows it while the queue is held in reset.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            logic [31:0] instr_reg;
            logic [31:0] addr_reg;

            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    instr_reg <= '0;
                    addr_reg  <= RESET_ADDR;
                end else if (push && (wr_ptr_reg == PW'(gi))) begin
                    instr_reg <= imem_rdata;
                    addr_reg  <= imem_addr_reg;
                end
            end

            assign entry_instr[gi] = instr_reg;
            assign entry_addr[gi]  = addr_reg;
        end
    endgenerate

endmodule

// File: doc/f_fetch_queue.md
F_FETCH_QUEUE -- requirements
Module: f_fetch_queue

Interface
REQ-001 Parameter: DEPTH, 4, number of queue entries; power of two, 2 or greater.
REQ-002 Parameter: RESET_ADDR, 32'h0000_3000, value driven on imem_addr and d_pc while idle after reset.
REQ-003 Port: clk  input  1  single clock; all state updates on its rising edge.
REQ-004 Port: reset  input  1  asynchronous, active-low; asserted (0) forces the reset state immediately, independent of clk.
REQ-005 Port: pc  input  32  current fetch address from the PC register.
REQ-006 Port: pc_we  output  1  write enable back to the PC register; 1 lets the PC load its next value.
REQ-007 Port: flush  input  1  redirect pulse; discards queued and in-flight fetches.
REQ-008 Port: imem_req  output  1  instruction-memory read request, registered.
REQ-009 Port: imem_addr  output  32  read address, held stable while imem_req=1.
REQ-010 Port: imem_ack  input  1  memory completion; imem_rdata is valid in the same cycle.
REQ-011 Port: imem_rdata  input  32  instruction word.
REQ-012 Port: d_valid  output  1  queue head is valid for decode.
REQ-013 Port: d_ready  input  1  decode accepts the head this cycle.
REQ-014 Port: d_instr  output  32  instruction at the queue head.
REQ-015 Port: d_pc  output  32  fetch address of the queue head.

Function
REQ-016 States SHALL be IDLE, WAIT (request outstanding, result kept) and DROP (request outstanding, result discarded).
REQ-017 At most one memory request SHALL be outstanding at any time.
REQ-018 IDLE->WAIT SHALL occur when flush=0 and count<DEPTH; on that edge imem_addr<=pc and imem_req<=1.
REQ-019 imem_req SHALL be 1 in WAIT and in DROP, and 0 in IDLE.
REQ-020 In WAIT with imem_ack=1 and flush=0: push {imem_addr, imem_rdata}, go to IDLE, and assert pc_we=1 combinationally in that cycle.
REQ-021 pc_we SHALL equal (state==WAIT & imem_ack & !flush) | flush, so the PC holds at all other times.
REQ-022 flush=1 SHALL empty the queue at the next edge (count, rd_ptr and wr_ptr go to 0).
REQ-023 flush in WAIT with imem_ack=0 SHALL go to DROP.
REQ-024 flush in WAIT with imem_ack=1 SHALL discard the data and go to IDLE.
REQ-025 flush in IDLE SHALL prevent a request from issuing that cycle.
REQ-026 flush in DROP SHALL keep the block in DROP, or go to IDLE if imem_ack=1.
REQ-027 DROP with imem_ack=1 and flush=0 SHALL go to IDLE with no push and pc_we=0.
REQ-028 d_valid SHALL be (count!=0); d_instr and d_pc SHALL show the entry at rd_ptr.
REQ-029 Pop SHALL occur when d_valid & d_ready & !flush.
REQ-030 Simultaneous push and pop SHALL leave count unchanged; both pointers advance.
REQ-031 Pointers SHALL wrap modulo DEPTH; count SHALL be held within 0..DEPTH.
REQ-032 With count==DEPTH no request SHALL issue; an in-flight request SHALL NOT be issued into a full queue.
REQ-033 A request SHALL issue only when count (after any pop in the same cycle is accounted for at the next edge) is less than DEPTH at issue time.
REQ-034 Latency: with the queue empty and in IDLE at edge 0, imem_req=1 after edge 0; ack in cycle k gives d_valid=1 after edge k.

Reset
REQ-035 While reset=0: state=IDLE, imem_req=0, imem_addr=RESET_ADDR, count=0, both pointers 0, d_valid=0.
REQ-036 While reset=0: pc_we=0 and d_pc=RESET_ADDR.
REQ-037 Reset asserted mid-request SHALL abandon the request; a late imem_ack after reset release in IDLE SHALL be ignored.

Verification
REQ-038 Basic fetch: reset release, pc=0x3000, memory acks 2 cycles after request with 0x24010005 -> one pc_we pulse in the ack cycle; next cycle d_valid=1, d_pc=0x3000, d_instr=0x24010005.
REQ-039 Backpressure: d_ready=0, pc stepping 0x3000, 0x3004, ... with 1-cycle acks -> exactly 4 entries, 4 pc_we pulses, no 5th request; one pop -> a request for 0x3010 issues.
REQ-040 Flush in flight: flush asserted while waiting on 0x3008 with 2 entries queued -> next cycle d_valid=0, state DROP; the later ack causes no push and pc_we=0.
REQ-041 Flush with ack in the same cycle: WAIT, imem_ack=1 and flush=1 together -> single pc_we=1, queue empty, IDLE, new request on redirected pc the following cycle.
REQ-042 Push with pop and wrap: continuous 1-cycle acks with d_ready=1 for 10 instructions -> count stays at or below 1, d_pc increments by 4 in order, pointers wrap past DEPTH correctly.
REQ-043 Asynchronous reset: reset driven 0 between clock edges during WAIT -> imem_req=0 and d_valid=0 immediately, before the next edge.
